// File: rtl/mi_stream_master.sv
// Host-side sequencer for a word-serial modular-inverse engine: kicks the engine,
// streams operand/modulus words LSW first, then collects result words with a timeout.
module mi_stream_master #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [K*N-1:0] a_in,
  input  logic [K*N-1:0] p_in,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [K*N-1:0] r_out,
  output logic           mi_start,
  output logic [K-1:0]   word_a,
  output logic [K-1:0]   word_p,
  output logic           word_valid,
  input  logic [K-1:0]   res_word,
  input  logic           res_valid
);

  localparam int IDXW = $clog2(N) + 1;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KICK    = 3'd1,
    SEND    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] idx_reg;
  logic [IDXW-1:0] cnt_reg;
  logic [TW-1:0]   tmo_reg;
  logic            error_reg;
  logic [K-1:0]    a_sh_reg   [N];
  logic [K-1:0]    p_sh_reg   [N];
  logic [K-1:0]    res_words  [N];

  logic accept;
  logic last_accept;
  logic timeout_hit;

  assign accept      = (state_reg == COLLECT) && res_valid;
  assign last_accept = accept && (cnt_reg == IDXW'(N - 1));
  // A final word arriving on the timeout cycle still counts as a clean finish.
  assign timeout_hit = (state_reg == COLLECT) && !last_accept && (tmo_reg == TW'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    mi_start   = 1'b0;
    word_valid = 1'b0;
    word_a     = '0;
    word_p     = '0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = KICK;
      end
      KICK: begin
        mi_start   = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        word_valid = 1'b1;
        word_a     = a_sh_reg[idx_reg[IW-1:0]];
        word_p     = p_sh_reg[idx_reg[IW-1:0]];
        if (idx_reg == IDXW'(N - 1)) state_next = COLLECT;
      end
      COLLECT: begin
        if (last_accept || timeout_hit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      tmo_reg   <= '0;
      error_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_sh_reg[i]  <= '0;
        p_sh_reg[i]  <= '0;
        res_words[i] <= '0;
      end
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE && start) begin
        error_reg <= 1'b0;
        for (int i = 0; i < N; i++) begin
          a_sh_reg[i]  <= a_in[i*K +: K];
          p_sh_reg[i]  <= p_in[i*K +: K];
          res_words[i] <= '0;
        end
      end

      if (state_reg == SEND) idx_reg <= idx_reg + IDXW'(1);
      else                   idx_reg <= '0;

      // Counters are primed during SEND so they read zero on the first COLLECT cycle.
      if (state_reg == SEND) begin
        cnt_reg <= '0;
        tmo_reg <= '0;
      end else if (state_reg == COLLECT) begin
        tmo_reg <= tmo_reg + TW'(1);
        if (accept) cnt_reg <= cnt_reg + IDXW'(1);
      end

      if (accept) res_words[cnt_reg[IW-1:0]] <= res_word;

      if (timeout_hit) error_reg <= 1'b1;
    end
  end

  assign error = error_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rout
      assign r_out[gi*K +: K] = res_words[gi];
    end
  endgenerate

endmodule

// File: tb/tb_mi_stream_master.sv
// Directed bench for mi_stream_master at K=8, N=4, TIMEOUT=20.
module tb_mi_stream_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in, p_in;
  logic        busy, done, error;
  logic [31:0] r_out;
  logic        mi_start;
  logic [7:0]  word_a, word_p;
  logic        word_valid;
  logic [7:0]  res_word;
  logic        res_valid;

  int checks = 0;
  int errors = 0;

  mi_stream_master #(.K(8), .N(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .p_in(p_in),
    .busy(busy), .done(done), .error(error), .r_out(r_out),
    .mi_start(mi_start), .word_a(word_a), .word_p(word_p), .word_valid(word_valid),
    .res_word(res_word), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mi_start"}, mi_start, 0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_word_a"}, word_a, 0);
    chk({tag, "_word_p"}, word_p, 0);
  endtask

  // From IDLE: start, check the kick and the four streamed words, end in the first COLLECT cycle.
  task automatic run_send(input logic [31:0] a, input logic [31:0] p, input bit busy_start);
    a_in = a; p_in = p; start = 1'b1;
    step();
    $display("txn start a=%h p=%h", a, p);
    chk("kick_mi_start", mi_start, 1);
    chk("kick_busy", busy, 1);
    chk("kick_word_valid", word_valid, 0);
    chk("kick_error_clr", error, 0);
    chk("kick_rout_clr", r_out, 0);
    start = 1'b0;
    step();
    chk("send_mi_start_off", mi_start, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("send_valid", word_valid, 1);
      chk("send_word_a", word_a, a[i*8 +: 8]);
      chk("send_word_p", word_p, p[i*8 +: 8]);
      if (busy_start && i == 1) begin
        start = 1'b1; a_in = 32'hFFFF_FFFF; p_in = 32'hFFFF_FFFF;
      end
      if (busy_start && i == 2) start = 1'b0;
    end
    step();
    chk("collect_valid_off", word_valid, 0);
    chk("collect_word_a_zero", word_a, 0);
    chk("collect_busy", busy, 1);
    chk("collect_done_low", done, 0);
  endtask

  // From the first COLLECT cycle: feed four words, end in the DONE cycle with res_valid low.
  task automatic feed4(input logic [31:0] r);
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1; res_word = r[i*8 +: 8];
      step();
    end
    res_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_rout", r_out, r);
    chk("done_error", error, 0);
    $display("txn done r_out=%h error=%b", r_out, error);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; a_in = '0; p_in = '0; res_word = '0; res_valid = 1'b0;
    step(); step();
    chk_idle_outputs("reset");
    chk("reset_error", error, 0);
    chk("reset_rout", r_out, 0);
    rst_n = 1'b1;
    step();

    // Basic run; start offered in DONE must be ignored.
    run_send(32'h0403_0201, 32'h4433_2211, 1'b0);
    feed4(32'hDDCC_BBAA);
    start = 1'b1;
    step();
    chk("done_start_ignored_busy", busy, 0);
    chk("after_done_pulse_low", done, 0);
    chk("after_done_rout_held", r_out, 32'hDDCC_BBAA);
    start = 1'b0;
    step();
    chk("idle_stays", busy, 0);

    // Stuck res_valid after the last word.
    run_send(32'h1122_3344, 32'h5566_7788, 1'b0);
    feed4(32'h0403_0201);
    res_valid = 1'b1; res_word = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stuck_rout", r_out, 32'h0403_0201);
      chk("stuck_done", done, 0);
    end
    res_valid = 1'b0;
    $display("txn stuck-valid r_out=%h", r_out);

    // Timeout after two words.
    run_send(32'h0A0B_0C0D, 32'h1A1B_1C1D, 1'b0);
    n = 0;
    res_valid = 1'b1; res_word = 8'h11;
    step(); n++;
    res_word = 8'h22;
    step(); n++;
    res_valid = 1'b0;
    while (!done && n < 40) begin
      step(); n++;
    end
    chk("timeout_cycles", n, 20);
    chk("timeout_error", error, 1);
    chk("timeout_rout", r_out, 32'h0000_2211);
    $display("txn timeout cycles=%0d error=%b r_out=%h", n, error, r_out);
    step();
    chk("timeout_idle", busy, 0);
    chk("timeout_error_held", error, 1);

    // Back-to-back: new start clears error and r_out.
    run_send(32'hC0C1_C2C3, 32'hD0D1_D2D3, 1'b0);
    feed4(32'h8D7C_6B5A);
    step();

    // Start pulsed mid-SEND with a different operand.
    run_send(32'h0D0C_0B0A, 32'h1D1C_1B1A, 1'b1);
    feed4(32'h1357_9BDF);
    step();
    chk("busy_start_idle", busy, 0);

    // Reset during SEND.
    a_in = 32'h0403_0201; p_in = 32'h4433_2211; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_reset_word_a", word_a, 8'h02);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_error", error, 0);
    chk("async_reset_rout", r_out, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_no_done", done, 0);
      chk("post_reset_idle", busy, 0);
    end
    $display("txn reset mid-send");
    run_send(32'h2468_ACE0, 32'h1357_9BDF, 1'b0);
    feed4(32'hCAFE_F00D);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
